shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the word width in bits (range 2..16).
REQ-002 Parameter DEPTH, default 2, SHALL set the output buffer depth in words (power of two, 2..8).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 serial_data_in  input  1  SHALL carry the serial bit stream, sampled only when shift_en=1.
REQ-006 shift_en  input  1  SHALL qualify serial_data_in for one bit per cycle.
REQ-007 parallel_data_out  output  WIDTH  SHALL present the oldest buffered word.
REQ-008 data_valid  output  1  SHALL indicate that parallel_data_out holds a valid word.
REQ-009 data_ready  input  1  SHALL indicate consumer acceptance; transfer occurs when data_valid&&data_ready.
REQ-010 overflow  output  1  SHALL be a sticky flag set when a completed word is dropped because the buffer is full.
REQ-011 parity_err  output  1  SHALL be a sticky flag for parity mismatch (see Configuration).

Function
REQ-012 Bits SHALL be assembled MSB first: the first sampled bit lands in parallel_data_out[WIDTH-1].
REQ-013 The FSM SHALL have states COLLECT and PARITY; PARITY exists only when SERIAL_PARITY_EN is defined.
REQ-014 In COLLECT, each shift_en cycle SHALL shift one bit in and increment bit_cnt (0..WIDTH-1).
REQ-015 On the shift_en cycle with bit_cnt=WIDTH-1, bit_cnt SHALL wrap to 0 and the word SHALL complete (or the FSM enters PARITY).
REQ-016 A completed word SHALL be pushed into the buffer on that same edge; data_valid SHALL assert the following cycle when the buffer was empty (1-cycle latency from last bit).
REQ-017 Cycles with shift_en=0 SHALL hold bit_cnt and the partial word; there is no timeout.
REQ-018 A push SHALL be accepted if the buffer is not full, or if it is full and a pop occurs in the same cycle.
REQ-019 A push into a full buffer without a simultaneous pop SHALL drop the word, leave buffer contents unchanged, and set overflow.
REQ-020 Buffer pointers SHALL wrap modulo DEPTH; words SHALL leave in arrival order.
REQ-021 parallel_data_out SHALL be stable while data_valid=1 and data_ready=0.
REQ-022 overflow and parity_err SHALL clear only on reset.

Reset
REQ-023 Reset SHALL asynchronously force FSM=COLLECT, bit_cnt=0, partial word=0, buffer empty, data_valid=0, parallel_data_out=0, overflow=0, parity_err=0.
REQ-024 Reset asserted mid-word SHALL discard the partial word; collection restarts at bit 0 on the first shift_en after release.

Configuration
REQ-025 Macro SERIAL_PARITY_EN defined: each frame SHALL be WIDTH data bits plus one even-parity bit; in PARITY, the next shift_en bit is checked, a match pushes the word, a mismatch drops it and sets parity_err; the FSM then returns to COLLECT.
REQ-026 Macro SERIAL_PARITY_EN undefined: frames SHALL be WIDTH bits, the PARITY state SHALL not exist, and parity_err SHALL be tied to 0.

Structure
REQ-027 Package shift_deser_pkg SHALL hold the FSM state enum typedef and default WIDTH/DEPTH constants.
REQ-028 The output buffer SHALL be a sub-module deser_fifo (push/pop/full/empty, DEPTH x WIDTH).

Verification
REQ-029 Send 1,0,1,1 with shift_en every cycle and data_ready=1 -> parallel_data_out=4'hB, data_valid=1 for one cycle, 1 cycle after the last bit.
REQ-030 Send 4'hA and 4'h5 back-to-back with data_ready=0, then a third word 4'hF -> overflow=1; raise data_ready -> 4'hA then 4'h5 out, 4'hF absent.
REQ-031 Buffer full and third word completing in the same cycle as a pop -> no overflow; outputs 4'hA, 4'h5, 4'hF in order.
REQ-032 Send 2 bits of a word, pulse reset, then send 0,0,1,1 -> output 4'h3 only; all flags 0.
REQ-033 Interleave shift_en=0 gaps between the bits of 4'h6 -> output 4'h6; bit_cnt held during gaps.
REQ-034 SERIAL_PARITY_EN defined: send 4'h7 with parity bit 1 -> 4'h7 out; send 4'h7 with parity bit 0 -> word dropped, parity_err=1.

Source files
------------

// File: rtl/shift_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// shift_deser_pkg
// Shared types and constants for the serial-to-parallel deserializer.
//   DEFAULT_WIDTH : default word width in bits
//   DEFAULT_DEPTH : default output buffer depth in words
//   deser_state_e : collector FSM states. PARITY is present only when
//                   SERIAL_PARITY_EN is defined.
//   even_parity() : XOR-reduction helper for the optional parity check.
// Optional feature macro: SERIAL_PARITY_EN
// -----------------------------------------------------------------------------
package shift_deser_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 2;

`ifdef SERIAL_PARITY_EN
  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } deser_state_e;
`else
  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0
  } deser_state_e;
`endif

  // Even-parity bit for up to 16 data bits (caller zero-extends narrower words).
  function automatic logic even_parity(input logic [15:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// -----------------------------------------------------------------------------
// shift_deserializer_if
// Bundles the serial input, the parallel valid/ready output and the status
// flags of the deserializer.
//   serial_data_in    : serial bit stream (producer -> deserializer)
//   shift_en          : qualifies serial_data_in, one bit per cycle
//   data_ready        : consumer accepts the presented word
//   parallel_data_out : oldest buffered word
//   data_valid        : parallel_data_out holds a valid word
//   overflow          : sticky, a completed word was dropped (buffer full)
//   parity_err        : sticky, a frame failed its parity check
// Modports: master = stimulus/consumer side, slave = deserializer side.
// -----------------------------------------------------------------------------
import shift_deser_pkg::*;

interface shift_deserializer_if #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             serial_data_in;
  logic             shift_en;
  logic             data_ready;
  logic [WIDTH-1:0] parallel_data_out;
  logic             data_valid;
  logic             overflow;
  logic             parity_err;

  modport master (
    output serial_data_in,
    output shift_en,
    output data_ready,
    input  parallel_data_out,
    input  data_valid,
    input  overflow,
    input  parity_err
  );

  modport slave (
    input  serial_data_in,
    input  shift_en,
    input  data_ready,
    output parallel_data_out,
    output data_valid,
    output overflow,
    output parity_err
  );
endinterface

// File: rtl/shift_deserializer_fifo.sv
// -----------------------------------------------------------------------------
// deser_fifo
// DEPTH x WIDTH output buffer with registered head word and valid flag.
//   clk, reset   : clock, asynchronous active-high reset
//   i_push       : write i_push_data (accepted when not full, or full + pop)
//   i_push_data  : word to buffer
//   i_pop        : remove the head word
//   o_full       : buffer holds DEPTH words
//   o_empty      : buffer holds no words
//   o_valid      : registered "not empty", aligned with o_data
//   o_data       : registered head (oldest) word
// -----------------------------------------------------------------------------
import shift_deser_pkg::*;

module deser_fifo #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_mem_nxt [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_full, w_empty, w_do_push, w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_do_pop  = i_pop && !w_empty;
  // A full buffer still takes the new word when the head leaves on the same edge.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    w_mem_nxt    = r_mem;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_do_push) begin
      w_mem_nxt[r_wr_ptr] = i_push_data;
      w_wr_ptr_nxt        = r_wr_ptr + PTR_W'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_do_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage and registered head-of-queue outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_valid  <= 1'b0;
      r_data   <= {WIDTH{1'b0}};
    end else begin
      r_mem    <= w_mem_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      // Head word is pre-fetched from next-state storage so it is valid
      // on the very cycle after the first push.
      r_valid  <= (w_count_nxt != {CNT_W{1'b0}});
      r_data   <= w_mem_nxt[w_rd_ptr_nxt];
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/shift_deserializer.sv
// -----------------------------------------------------------------------------
// shift_deserializer
// Assembles a serial bit stream (MSB first) into WIDTH-bit words and queues
// them in a DEPTH-word buffer with a valid/ready output handshake.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : shift_deserializer_if.slave (serial input, shift_en, data_ready,
//           parallel_data_out, data_valid, overflow, parity_err)
// Optional feature macro: SERIAL_PARITY_EN -- each frame carries one extra
// even-parity bit; failing frames are dropped and raise parity_err.
// Without it parity_err is tied low.
// -----------------------------------------------------------------------------
import shift_deser_pkg::*;

module shift_deserializer #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  shift_deserializer_if.slave bus
);
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  deser_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  // Only WIDTH-1 bits are stored: the final bit completes the word directly.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_last_bit;
  logic             w_collect;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic             w_pop;
  logic             w_drop;
  logic             w_fifo_full, w_fifo_empty, w_fifo_valid;
  logic [WIDTH-1:0] w_fifo_data;
  logic             r_overflow;
`ifdef SERIAL_PARITY_EN
  logic [WIDTH-1:0] r_word;
  logic [15:0]      w_par_vec;
  logic             w_parity_fail;
  logic             r_parity_err;
`endif

  assign w_word     = {r_shift, bus.serial_data_in};
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: begin
`ifdef SERIAL_PARITY_EN
        if (bus.shift_en && w_last_bit) begin
          w_state_nxt = ST_PARITY;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
`else
        w_state_nxt = ST_COLLECT;
`endif
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: begin
        if (bus.shift_en) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
`endif
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  // FSM outputs: shift strobe, buffer push and parity verdict.
  always_comb begin
    w_collect   = 1'b0;
    w_push      = 1'b0;
    w_push_data = w_word;
`ifdef SERIAL_PARITY_EN
    w_parity_fail          = 1'b0;
    w_par_vec              = 16'h0000;
    w_par_vec[WIDTH-1:0]   = r_word;
`endif
    case (r_state)
      ST_COLLECT: begin
        w_collect = bus.shift_en;
`ifndef SERIAL_PARITY_EN
        if (bus.shift_en && w_last_bit) begin
          w_push = 1'b1;
        end else begin
          w_push = 1'b0;
        end
`endif
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: begin
        w_push_data = r_word;
        if (bus.shift_en) begin
          if (even_parity(w_par_vec) == bus.serial_data_in) begin
            w_push = 1'b1;
          end else begin
            w_parity_fail = 1'b1;
          end
        end else begin
          w_push = 1'b0;
        end
      end
`endif
      default: begin
        w_collect = 1'b0;
        w_push    = 1'b0;
      end
    endcase
  end

  // Shift register and bit counter; both hold on shift_en=0 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= {(WIDTH-1){1'b0}};
      r_bit_cnt <= {CNT_W{1'b0}};
    end else if (w_collect) begin
      r_shift <= w_word[WIDTH-2:0];
      if (w_last_bit) begin
        r_bit_cnt <= {CNT_W{1'b0}};
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SERIAL_PARITY_EN
  // Completed data word parked here while its parity bit arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= {WIDTH{1'b0}};
    end else if (w_collect && w_last_bit) begin
      r_word <= w_word;
    end
  end
`endif

  assign w_pop  = w_fifo_valid && bus.data_ready && !w_fifo_empty;
  assign w_drop = w_push && w_fifo_full && !w_pop;

  deser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data)
  );

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow | w_drop;
    end
  end

`ifdef SERIAL_PARITY_EN
  // Sticky parity error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= r_parity_err | w_parity_fail;
    end
  end
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.parallel_data_out = w_fifo_data;
  assign bus.data_valid        = w_fifo_valid;
  assign bus.overflow          = r_overflow;

endmodule

// File: tb/tb_shift_deserializer.sv
// -----------------------------------------------------------------------------
// tb_shift_deserializer
// Self-checking bench: a table of words driven through the serial input plus
// hand-written sequences for overflow, same-cycle pop, mid-word reset, idle
// gaps and (with SERIAL_PARITY_EN) parity. Expected words go into a queue at
// stimulus time and are popped by a monitor on each accepted output word.
// -----------------------------------------------------------------------------
import shift_deser_pkg::*;

module tb_shift_deserializer;
  localparam int W = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_deserializer_if #(.WIDTH(W)) bus ();

  shift_deserializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] word;
    int           gap;
  } vec_t;

  int           n_cmp;
  int           n_fail;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted output word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.data_valid && bus.data_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)",
                 bus.parallel_data_out, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        check("scoreboard_word", 32'(bus.parallel_data_out), 32'(mon_exp));
      end
    end
  end

  function automatic int frame_len();
`ifdef SERIAL_PARITY_EN
    return W + 1;
`else
    return W;
`endif
  endfunction

  function automatic logic frame_bit(input logic [W-1:0] w, input int i, input logic par);
    if (i < W) return w[W-1-i];
    else       return par;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.serial_data_in = b;
    bus.shift_en       = 1'b1;
    @(posedge clk);
    #1;
    bus.shift_en       = 1'b0;
    bus.serial_data_in = 1'b0;
  endtask

  task automatic send_partial(input logic [W-1:0] w, input logic par, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      send_bit(frame_bit(w, i, par));
      if (gap > 0 && i < nbits - 1) idle(gap);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    send_partial(w, ^w, frame_len(), gap);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) idle(1);
    check("drain_complete", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    tbl[0] = '{4'h0, 0};
    tbl[1] = '{4'hF, 0};
    tbl[2] = '{4'h9, 0};
    tbl[3] = '{4'h6, 2};
    tbl[4] = '{4'h1, 0};
    tbl[5] = '{4'h8, 1};
    tbl[6] = '{4'hC, 0};
    tbl[7] = '{4'h3, 3};

    reset              = 1'b1;
    bus.serial_data_in = 1'b0;
    bus.shift_en       = 1'b0;
    bus.data_ready     = 1'b0;
    idle(2);
    check("reset_valid", 32'(bus.data_valid), 32'd0);
    check("reset_data", 32'(bus.parallel_data_out), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    check("reset_parity_err", 32'(bus.parity_err), 32'd0);
    reset = 1'b0;
    idle(1);

    // Basic word 1,0,1,1 -> B, valid for exactly one cycle after the last bit.
    bus.data_ready = 1'b1;
    sb_q.push_back(4'hB);
    send_word(4'hB, 0);
    check("first_valid", 32'(bus.data_valid), 32'd1);
    check("first_data", 32'(bus.parallel_data_out), 32'hB);
    idle(1);
    check("first_valid_drop", 32'(bus.data_valid), 32'd0);

    // Table of words, some with idle gaps between bits.
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(tbl[k].word);
      send_word(tbl[k].word, tbl[k].gap);
      check("table_valid", 32'(bus.data_valid), 32'd1);
      check("table_data", 32'(bus.parallel_data_out), 32'(tbl[k].word));
    end
    idle(1);
    check("table_idle_valid", 32'(bus.data_valid), 32'd0);

    // Overflow: A,5 fill the buffer, F is dropped.
    bus.data_ready = 1'b0;
    sb_q.push_back(4'hA);
    sb_q.push_back(4'h5);
    send_word(4'hA, 0);
    send_word(4'h5, 0);
    check("full_no_overflow", 32'(bus.overflow), 32'd0);
    check("full_head_data", 32'(bus.parallel_data_out), 32'hA);
    send_word(4'hF, 0);
    check("overflow_set", 32'(bus.overflow), 32'd1);
    idle(3);
    check("stall_valid", 32'(bus.data_valid), 32'd1);
    check("stall_data_stable", 32'(bus.parallel_data_out), 32'hA);
    bus.data_ready = 1'b1;
    drain();
    check("overflow_sticky", 32'(bus.overflow), 32'd1);
    check("after_drain_valid", 32'(bus.data_valid), 32'd0);
    pulse_reset();
    check("overflow_cleared", 32'(bus.overflow), 32'd0);
    idle(1);

    // Full buffer, third word completes on the same edge as a pop.
    bus.data_ready = 1'b0;
    sb_q.push_back(4'hA);
    sb_q.push_back(4'h5);
    sb_q.push_back(4'hF);
    send_word(4'hA, 0);
    send_word(4'h5, 0);
    send_partial(4'hF, ^(4'hF), frame_len() - 1, 0);
    bus.data_ready = 1'b1;
    send_bit(frame_bit(4'hF, frame_len() - 1, ^(4'hF)));
    check("simul_pop_no_overflow", 32'(bus.overflow), 32'd0);
    drain();
    check("simul_pop_overflow_end", 32'(bus.overflow), 32'd0);

    // Reset in the middle of a word discards the partial bits.
    send_bit(1'b1);
    send_bit(1'b0);
    pulse_reset();
    check("midreset_valid", 32'(bus.data_valid), 32'd0);
    sb_q.push_back(4'h3);
    send_word(4'h3, 0);
    check("midreset_data", 32'(bus.parallel_data_out), 32'h3);
    idle(1);
    check("midreset_overflow", 32'(bus.overflow), 32'd0);
    check("midreset_parity_err", 32'(bus.parity_err), 32'd0);

    // Idle gaps between bits hold the bit counter.
    sb_q.push_back(4'h6);
    for (int i = 0; i < frame_len(); i++) begin
      send_bit(frame_bit(4'h6, i, ^(4'h6)));
      if (i < frame_len() - 1) begin
        idle(2);
        check("gap_no_valid", 32'(bus.data_valid), 32'd0);
      end
    end
    check("gap_valid", 32'(bus.data_valid), 32'd1);
    check("gap_data", 32'(bus.parallel_data_out), 32'h6);
    idle(1);

`ifdef SERIAL_PARITY_EN
    // Parity: good frame passes, bad frame is dropped.
    sb_q.push_back(4'h7);
    send_partial(4'h7, 1'b1, W + 1, 0);
    check("parity_good_valid", 32'(bus.data_valid), 32'd1);
    check("parity_good_data", 32'(bus.parallel_data_out), 32'h7);
    idle(1);
    send_partial(4'h7, 1'b0, W + 1, 0);
    check("parity_bad_dropped", 32'(bus.data_valid), 32'd0);
    check("parity_err_set", 32'(bus.parity_err), 32'd1);
    idle(2);
    check("parity_err_sticky", 32'(bus.parity_err), 32'd1);
`else
    check("parity_err_tied_low", 32'(bus.parity_err), 32'd0);
`endif

    idle(2);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
